// File: rtl/program_loader.sv
// Boot loader: writes a framed byte stream into program memory, then releases the core when the checksum matches.
// Define LOADER_TIMEOUT_EN to abort a frame after TIMEOUT_CYCLES idle cycles between bytes.
module program_loader #(
   parameter int         ADDR_W         = 8,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              sync_reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [ADDR_W-1:0] pm_wr_address,
   output logic [7:0]        pm_wr_data,
   output logic              pm_wren,
   output logic              cpu_reset,
   output logic              load_done,
   output logic              load_error
);
   localparam int               CNT_W   = ADDR_W + 1;
   localparam logic [CNT_W-1:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  len_cnt;
   logic [ADDR_W-1:0] wr_ptr;
   logic [7:0]        csum;
   logic              accept;

`ifdef LOADER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

   assign rx_ready = (state != DONE);
   assign accept   = rx_valid & rx_ready;

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state         <= IDLE;
         cpu_reset     <= 1'b1;
         pm_wren       <= 1'b0;
         pm_wr_address <= '0;
         pm_wr_data    <= '0;
         load_done     <= 1'b0;
         load_error    <= 1'b0;
         len_cnt       <= '0;
         csum          <= '0;
         wr_ptr        <= '0;
`ifdef LOADER_TIMEOUT_EN
         to_cnt        <= '0;
`endif
      end else begin
         pm_wren <= 1'b0;
         case (state)
            IDLE: if (accept && rx_data == SYNC_BYTE) begin
               load_error <= 1'b0;
               csum       <= '0;
               wr_ptr     <= '0;
               state      <= LEN;
            end
            LEN: if (accept) begin
               // a zero length field encodes the full memory size
               len_cnt <= (rx_data == 8'd0) ? LEN_MAX : CNT_W'(rx_data);
               state   <= DATA;
            end
            DATA: if (accept) begin
               csum          <= csum + rx_data;
               pm_wren       <= 1'b1;
               pm_wr_data    <= rx_data;
               pm_wr_address <= wr_ptr;
               wr_ptr        <= wr_ptr + 1'b1;
               len_cnt       <= len_cnt - 1'b1;
               if (len_cnt == CNT_W'(1)) state <= CSUM;
            end
            CSUM: if (accept) begin
               if (rx_data == csum) begin
                  state     <= DONE;
                  load_done <= 1'b1;
                  cpu_reset <= 1'b0;
               end else begin
                  state      <= IDLE;
                  load_error <= 1'b1;
               end
            end
            default: ;
         endcase
`ifdef LOADER_TIMEOUT_EN
         // placed after the case so an expiry overrides any state update above
         if (state inside {LEN, DATA, CSUM}) begin
            if (accept) begin
               to_cnt <= '0;
            end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
               to_cnt     <= '0;
               state      <= IDLE;
               load_error <= 1'b1;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
         end else begin
            to_cnt <= '0;
         end
`endif
      end
   end
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table vectors, hand sequences and random frames checked against a frame-level model.
module tb_program_loader;
   localparam logic [7:0] SYNC = 8'hA5;

   typedef logic [7:0] bq_t [$];
   typedef struct { int cyc; logic [7:0] a; logic [7:0] d; } wlog_t;
   typedef struct { logic [7:0] a; logic [7:0] d; int idx; } mw_t;
   typedef mw_t mwq_t [$];
   typedef struct packed {
      logic [95:0] bytes;   // byte 0 in the top octet
      logic [3:0]  len;
      logic [1:0]  gap;
      logic        exp_done;
      logic        exp_err;
      logic [8:0]  exp_nwr;
   } vec_t;

   logic       clk = 1'b0;
   logic       sync_reset = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       rx_ready;
   logic [7:0] pm_wr_address;
   logic [7:0] pm_wr_data;
   logic       pm_wren;
   logic       cpu_reset;
   logic       load_done;
   logic       load_error;

   int    n_vec = 0;
   int    n_bad = 0;
   int    cyc = 0;
   int    cpu_fall_cyc = -1;
   wlog_t wr_log [$];
   int    hs_log [$];
   vec_t  tbl [8];

   program_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .sync_reset(sync_reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .pm_wr_address(pm_wr_address), .pm_wr_data(pm_wr_data),
      .pm_wren(pm_wren), .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error)
   );

   always #5 clk = ~clk;

   // handshakes are stamped with the cycle that ends on this edge
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (sync_reset) hs_log.delete();
      else if (rx_valid && rx_ready) hs_log.push_back(cyc);
   end

   always @(negedge clk) begin
      if (sync_reset) begin
         wr_log.delete();
         cpu_fall_cyc <= -1;
      end else begin
         if (pm_wren) wr_log.push_back('{cyc, pm_wr_address, pm_wr_data});
         if (!cpu_reset && cpu_fall_cyc < 0) cpu_fall_cyc <= cyc;
      end
   end

   function automatic void chk(string nm, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endfunction

   task automatic idle(int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset(string nm);
      sync_reset = 1'b1;
      rx_valid   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk({nm, ".rst_wren"},  int'(pm_wren), 0);
      chk({nm, ".rst_cpu"},   int'(cpu_reset), 1);
      chk({nm, ".rst_done"},  int'(load_done), 0);
      chk({nm, ".rst_err"},   int'(load_error), 0);
      chk({nm, ".rst_ready"}, int'(rx_ready), 1);
      chk({nm, ".rst_addr"},  int'(pm_wr_address), 0);
      chk({nm, ".rst_data"},  int'(pm_wr_data), 0);
      sync_reset = 1'b0;
   endtask

   // drives the stream with 0..max_gap idle cycles before each byte; stops once the loader no longer accepts
   task automatic send(input bq_t s, input int max_gap);
      int g;
      foreach (s[i]) begin
         g = $urandom_range(max_gap, 0);
         repeat (g) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(posedge clk); #1;
         end
         if (!rx_ready) break;
         rx_valid = 1'b1;
         rx_data  = s[i];
         @(posedge clk); #1;
      end
      rx_valid = 1'b0;
   endtask

   // frame-level reference: scan for sync, take the length, sum the payload, compare the trailer
   task automatic model(input bq_t s, output mwq_t w, output logic done, output logic err, output int didx);
      int i, n, j;
      logic [7:0] sum;
      logic cut;
      w.delete();
      done = 1'b0; err = 1'b0; didx = -1; i = 0; cut = 1'b0;
      while (i < s.size() && !done && !cut) begin
         if (s[i] != SYNC) i++;
         else if (i + 1 >= s.size()) cut = 1'b1;
         else begin
            err = 1'b0;
            sum = 8'h00;
            n = (s[i+1] == 8'd0) ? 256 : int'(s[i+1]);
            for (int k = 0; k < n && !cut; k++) begin
               if (i + 2 + k >= s.size()) cut = 1'b1;
               else begin
                  w.push_back('{k[7:0], s[i+2+k], i + 2 + k});
                  sum += s[i+2+k];
               end
            end
            j = i + 2 + n;
            if (!cut && j >= s.size()) cut = 1'b1;
            if (!cut) begin
               if (s[j] == sum) begin done = 1'b1; didx = j; end
               else err = 1'b1;
            end
            i = j + 1;
         end
      end
   endtask

   task automatic check_frame(input bq_t s, input string nm);
      mwq_t w;
      logic done, err;
      int didx, bad, want_cyc;
      model(s, w, done, err, didx);
      chk({nm, ".nwr"}, wr_log.size(), w.size());
      bad = -1;
      for (int k = 0; k < w.size() && k < wr_log.size(); k++) begin
         want_cyc = (w[k].idx < hs_log.size()) ? hs_log[w[k].idx] + 1 : -2;
         if (bad < 0 && (wr_log[k].a != w[k].a || wr_log[k].d != w[k].d || wr_log[k].cyc != want_cyc))
            bad = k;
      end
      n_vec++;
      if (bad >= 0) begin
         n_bad++;
         want_cyc = (w[bad].idx < hs_log.size()) ? hs_log[w[bad].idx] + 1 : -2;
         $display("FAIL %s.wr[%0d]: got addr=%h data=%h cyc=%0d, want addr=%h data=%h cyc=%0d",
                  nm, bad, wr_log[bad].a, wr_log[bad].d, wr_log[bad].cyc, w[bad].a, w[bad].d, want_cyc);
      end
      chk({nm, ".done"},  int'(load_done), int'(done));
      chk({nm, ".err"},   int'(load_error), int'(err));
      chk({nm, ".cpu"},   int'(cpu_reset), int'(!done));
      chk({nm, ".ready"}, int'(rx_ready), int'(!done));
      if (done)
         chk({nm, ".cpu_fall"}, cpu_fall_cyc, (didx < hs_log.size()) ? hs_log[didx] + 1 : -2);
   endtask

   task automatic run_table();
      bq_t s;
      string nm;
      tbl[0] = '{96'hA5031122_33660000_00000000, 4'd6,  2'd0, 1'b1, 1'b0, 9'd3};
      tbl[1] = '{96'h00FFA501_7E7E0000_00000000, 4'd6,  2'd3, 1'b1, 1'b0, 9'd1};
      tbl[2] = '{96'hA5021020_31000000_00000000, 4'd5,  2'd1, 1'b0, 1'b1, 9'd2};
      tbl[3] = '{96'hA5021020_31A50210_20300000, 4'd10, 2'd0, 1'b1, 1'b0, 9'd4};
      tbl[4] = '{96'h5A11A501_A5A50000_00000000, 4'd6,  2'd2, 1'b1, 1'b0, 9'd1};
      tbl[5] = '{96'hA5010102_A5010000_00000000, 4'd8,  2'd0, 1'b1, 1'b0, 9'd2};
      tbl[6] = '{96'hA5014444_A5010000_00000000, 4'd6,  2'd1, 1'b1, 1'b0, 9'd1};
      tbl[7] = '{96'hA5011011_A5030100_00000000, 4'd7,  2'd0, 1'b0, 1'b0, 9'd2};
      for (int t = 0; t < 8; t++) begin
         nm = $sformatf("tbl%0d", t);
         s.delete();
         for (int i = 0; i < int'(tbl[t].len); i++) s.push_back(tbl[t].bytes[95 - 8*i -: 8]);
         do_reset(nm);
         send(s, int'(tbl[t].gap));
         idle(3);
         chk({nm, ".t_nwr"},  wr_log.size(), int'(tbl[t].exp_nwr));
         chk({nm, ".t_done"}, int'(load_done), int'(tbl[t].exp_done));
         chk({nm, ".t_err"},  int'(load_error), int'(tbl[t].exp_err));
         check_frame(s, nm);
      end
   endtask

   task automatic run_random(int r);
      bq_t s;
      int nf, nj, n;
      logic [7:0] sum, b;
      s.delete();
      nf = $urandom_range(3, 1);
      for (int f = 0; f < nf; f++) begin
         nj = $urandom_range(2, 0);
         n  = $urandom_range(24, 1);
         sum = 8'h00;
         repeat (nj) begin
            b = 8'($urandom);
            if (b == SYNC) b = 8'h00;
            s.push_back(b);
         end
         s.push_back(SYNC);
         s.push_back(n[7:0]);
         for (int k = 0; k < n; k++) begin
            b = 8'($urandom);
            s.push_back(b);
            sum += b;
         end
         s.push_back(($urandom_range(9, 0) < 3) ? (sum ^ 8'h5A) : sum);
      end
      do_reset($sformatf("rnd%0d", r));
      send(s, 2);
      idle(3);
      check_frame(s, $sformatf("rnd%0d", r));
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : main
      bq_t s;
      run_table();

      // full-size frame: length 0 means 256 bytes, pointer wraps without a 257th write
      s.delete();
      s.push_back(SYNC);
      s.push_back(8'h00);
      for (int k = 0; k < 256; k++) s.push_back(8'(k));
      s.push_back(8'h80);
      do_reset("n256");
      send(s, 1);
      idle(4);
      chk("n256.spec_done", int'(load_done), 1);
      check_frame(s, "n256");

      // reset in the cycle after the second data byte
      do_reset("sr");
      s = '{8'hA5, 8'h04, 8'h5C, 8'hC3};
      send(s, 0);
      sync_reset = 1'b1;
      rx_valid   = 1'b1;
      rx_data    = 8'h77;
      chk("sr.wren_pending", int'(pm_wren), 1);
      chk("sr.addr_pending", int'(pm_wr_address), 1);
      chk("sr.nwr_before", wr_log.size(), 1);
      @(posedge clk); #1;
      sync_reset = 1'b0;
      rx_valid   = 1'b0;
      chk("sr.wren", int'(pm_wren), 0);
      chk("sr.cpu", int'(cpu_reset), 1);
      chk("sr.ready", int'(rx_ready), 1);
      chk("sr.done", int'(load_done), 0);
      idle(2);
      chk("sr.no_write", wr_log.size(), 0);
      s = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03};
      send(s, 0);
      idle(3);
      check_frame(s, "sr.reload");

      // stalled frame: 16 idle cycles inside DATA
      do_reset("to");
      s = '{8'hA5, 8'h02, 8'hAA};
      send(s, 0);
      idle(16);
      chk("to.ready", int'(rx_ready), 1);
      chk("to.done", int'(load_done), 0);
`ifdef LOADER_TIMEOUT_EN
      chk("to.err", int'(load_error), 1);
      s = '{8'hBB, 8'h65};
      send(s, 0);
      idle(3);
      chk("to.err_after", int'(load_error), 1);
      chk("to.done_after", int'(load_done), 0);
      chk("to.nwr", wr_log.size(), 1);
`else
      chk("to.err", int'(load_error), 0);
      s = '{8'hBB, 8'h65};
      send(s, 0);
      idle(3);
      s = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h65};
      check_frame(s, "to.resume");
`endif

      for (int r = 0; r < 20; r++) run_random(r);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
